dptrace: RTL and testbench
==========================

# dptrace

Parametrised DisplayPort TX symbol trace buffer. Sits on the main-link transmit path next to the lane scramblers. It captures every lane's 2-symbol-per-clock data and K flags into a ring buffer, with a programmable pre-trigger depth and a masked symbol trigger evaluated on any lane and slot. Capture is software-armed, and the buffer is read back chronologically over the debug request/ack bus.

## Interface
- NLANE, 2: lane count; legal values 1, 2, 4; LG = log2(NLANE).
- NSZ, 10: log2 of capture depth; DEPTH = 1<<NSZ entries; NSZ+LG+2 <= 15.
- clk  in  1  sole clock; capture and bus both run on it.
- resetn  in  1  reset; synchronous, active-low.
- txdat  in  16*NLANE  lane l symbols at [16l+15:16l]; slot 0 = [7:0], slot 1 = [15:8].
- txisk  in  2*NLANE  K flag for lane l slot s at bit 2l+s.
- debugaddr  in  16  byte address; bit 15 = register space, else trace space.
- debugwdata  in  32  write data.
- debugwr  in  1  qualifies debugreq as write.
- debugreq  in  1  one-cycle request strobe.
- debugack  out  1  one-cycle completion strobe.
- debugrdata  out  32  read data, valid while debugack = 1.
- trigd  out  1  high in DONE.

## Operation
- Registers (addr[15] = 1, addr[4:2]):
  - 0 CTRL, write-only: b0 arm, b1 force trigger, b2 abort.
  - 1 STATUS: [2:0] state, [16+NSZ-1:16] trigptr.
  - 2 TRIGVAL: [7:0] symbol, [8] K.
  - 3 TRIGMASK: [7:0], [8]; a 1 means the bit is compared.
  - 4 PRETRIG: [NSZ-1:0].
  - Unmapped addresses read 0; writes to them are dropped.
- Trace read (addr[15] = 0):
  - Entry e = addr[NSZ+LG+1:LG+2]; lane = addr[LG+1:2].
  - Word = {14'b0, isk[1:0], dat[15:0]} of that lane.
  - e is relative to start = trigptr - PRETRIG (mod DEPTH), so e = PRETRIG is the trigger entry.
  - Writes to trace space are ignored.
- Trigger hit: any (lane, slot) with ((sym ^ TRIGVAL[7:0]) & TRIGMASK[7:0]) == 0 and ((k ^ TRIGVAL[8]) & TRIGMASK[8]) == 0, or a force strobe.
- Effective pretrigger pt = min(PRETRIG, DEPTH-1), latched at arm.
- States:
  - IDLE (0): no writes.
  - PRE (1): write every cycle, wptr++, count to pt. Hits ignored except force. Skipped when pt = 0.
  - ARMED (2): write every cycle; on hit, trigptr <= wptr of this cycle's entry → POST.
  - POST (3): write DEPTH-pt-1 further entries → DONE.
  - DONE (4): no writes; trigd = 1.
- Arm from any state: wptr <= 0 and go to PRE/ARMED. Abort → IDLE. Arm and abort in the same write: abort wins.
- Force in PRE: trigger at the current entry. Entries older than the number written are stale, and software accounts for this.
- wptr and trigptr are NSZ-bit and wrap modulo DEPTH.

## Timing
- Capture: txdat/txisk sampled at edge N are stored at wptr in the same edge. Trigger is evaluated combinationally on the same sample.
- Bus:
  - debugreq at edge N → debugack high for exactly edge N+2, with rdata valid then.
  - A register write takes effect at N+1; a CTRL strobe acts on the capture of cycle N+1.
  - debugreq while a request is pending (N+1, N+2) is ignored.
  - RAM read port is registered: one cycle of address, one cycle of output.
- Trace reads during capture are legal and return RAM contents without coherence guarantees.
- Reset: state IDLE, wptr/trigptr 0, TRIGVAL/TRIGMASK/PRETRIG 0, debugack 0, debugrdata 0, trigd 0, pending cleared. Mid-capture reset aborts; RAM contents are undefined.

## Structure
- dport.vh gains:
  - Register offsets TRCTRL..TRPRE.
  - State encodings TRIDLE..TRDONE.
  - CTRL bit positions.
  - symBE reused as the documented default trigger.
- Sub-module dptrace_ram: simple dual-port synchronous RAM, width 18*NLANE, depth DEPTH, one write port, registered read port. The top level holds the FSM, trigger compare, pointers and bus logic.

## Test plan
- NLANE=2, NSZ=4, PRETRIG=4, TRIGVAL=0x1BC, MASK=0x1FF; arm, ramp data, K 0xBC on lane 1 slot 1 at sample 20 → DONE after 11 more cycles; reading e=4 gives the BC word with isk b10; e=0..3 give samples 16..19.
- MASK=0 → trigger on the first ARMED cycle; PRETRIG=0 → PRE skipped, trigptr=0, POST writes 15 entries.
- PRETRIG=100 with DEPTH=16 → clamped to 15; trigger entry at e=15; DONE the cycle after the trigger is written.
- Force during PRE after 2 writes → trigptr=2, DONE after 16-pt-1 entries; abort mid-POST → IDLE and trigd stays 0.
- Bus: back-to-back debugreq at N and N+1 → a single ack at N+2; a write to TRIGVAL followed by a read returns the value; unmapped 0x8018 reads 0.
- resetn low during ARMED → all outputs 0 next edge; rearm works normally.

Source files
------------

// File: rtl/dptrace_pkg.sv
// Shared definitions for the DisplayPort TX symbol trace buffer: register map,
// capture state encodings, CTRL strobe bits and the symbol trigger compare.
package dptrace_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_TRIGVAL  = 3'd2;
  localparam logic [2:0] REG_TRIGMASK = 3'd3;
  localparam logic [2:0] REG_PRETRIG  = 3'd4;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_FORCE = 1;
  localparam int CTRL_ABORT = 2;

  // K28.5 comma, the usual trigger to program into TRIGVAL
  localparam logic [8:0] SYM_BE = 9'h1BC;

  typedef enum logic [2:0] {
    TR_IDLE  = 3'd0,
    TR_PRE   = 3'd1,
    TR_ARMED = 3'd2,
    TR_POST  = 3'd3,
    TR_DONE  = 3'd4
  } tr_state_e;

  function automatic logic sym_match(input logic [7:0] sym, input logic isk,
                                     input logic [8:0] val, input logic [8:0] mask);
    return ((({isk, sym} ^ val) & mask) == 9'd0);
  endfunction

endpackage

// File: rtl/dptrace_ram.sv
// Simple dual-port capture RAM: one synchronous write port, registered read port.
module dptrace_ram #(
  parameter int W  = 36,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dptrace.sv
// DisplayPort TX symbol trace buffer: capture FSM, symbol trigger, pointers and debug bus.
//   state    | meaning
//   TR_IDLE  | not capturing
//   TR_PRE   | filling pre-trigger history, only force triggers
//   TR_ARMED | capturing, waiting for a symbol hit or force
//   TR_POST  | capturing the post-trigger tail
//   TR_DONE  | capture complete, trigd high
module dptrace
  import dptrace_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int NSZ   = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [16*NLANE-1:0] txdat,
  input  logic [2*NLANE-1:0]  txisk,
  input  logic [15:0]         debugaddr,
  input  logic [31:0]         debugwdata,
  input  logic                debugwr,
  input  logic                debugreq,
  output logic                debugack,
  output logic [31:0]         debugrdata,
  output logic                trigd
);

  localparam int LG    = $clog2(NLANE);
  localparam int LGW   = (LG == 0) ? 1 : LG;
  localparam int DEPTH = 1 << NSZ;
  localparam int W     = 18 * NLANE;

  tr_state_e        state_q, state_d;
  logic [NSZ-1:0]   wptr_q, wptr_d, trigptr_q, trigptr_d, cnt_q, cnt_d, pt_q, pt_d;
  logic [8:0]       trigval_q, trigval_d, trigmask_q, trigmask_d;
  logic [15:0]      pretrig_q, pretrig_d;
  logic             pend_q, pend_d, ack_q, ack_d, wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d, regrd_q, regrd_d;

  logic             reg_wr, ctrl_wr, arm, force_trig, abort, hit, trig_now, ram_we;
  logic [NSZ-1:0]   pt_eff, post_len, ram_raddr;
  logic [W-1:0]     ram_wdata, ram_rdata;
  logic [LGW-1:0]   lane_sel;
  logic [31:0]      status_w, trace_word;
  logic             unused_bus;

  assign reg_wr     = pend_q & wr_q & addr_q[15];
  assign ctrl_wr    = reg_wr & (addr_q[4:2] == REG_CTRL);
  assign arm        = ctrl_wr & wdata_q[CTRL_ARM];
  assign force_trig = ctrl_wr & wdata_q[CTRL_FORCE];
  assign abort      = ctrl_wr & wdata_q[CTRL_ABORT];

  // PRETRIG is held wider than the pointer so oversized values clamp instead of aliasing
  assign pt_eff   = (pretrig_q > 16'(DEPTH - 1)) ? NSZ'(DEPTH - 1) : pretrig_q[NSZ-1:0];
  assign post_len = NSZ'(DEPTH - 1) - pt_q;
  assign status_w = {{(16-NSZ){1'b0}}, trigptr_q, 13'd0, state_q};

  always_comb begin
    hit = 1'b0;
    for (int l = 0; l < NLANE; l++)
      for (int s = 0; s < 2; s++)
        if (sym_match(txdat[16*l+8*s +: 8], txisk[2*l+s], trigval_q, trigmask_q)) hit = 1'b1;
  end

  always_comb begin
    ram_wdata = '0;
    for (int l = 0; l < NLANE; l++) ram_wdata[18*l +: 18] = {txisk[2*l +: 2], txdat[16*l +: 16]};
  end

  assign trig_now = ((state_q == TR_PRE) & force_trig) |
                    ((state_q == TR_ARMED) & (force_trig | hit));

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    trigptr_d = trigptr_q;
    cnt_d     = cnt_q;
    pt_d      = pt_q;
    ram_we    = 1'b0;
    if (abort) begin
      state_d = TR_IDLE;
    end else if (arm) begin
      wptr_d  = '0;
      pt_d    = pt_eff;
      cnt_d   = pt_eff;
      state_d = (pt_eff == '0) ? TR_ARMED : TR_PRE;
    end else begin
      case (state_q)
        TR_PRE: begin
          ram_we = 1'b1;
          wptr_d = wptr_q + NSZ'(1);
          cnt_d  = cnt_q - NSZ'(1);
          if (cnt_q == NSZ'(1)) state_d = TR_ARMED;
        end
        TR_ARMED: begin
          ram_we = 1'b1;
          wptr_d = wptr_q + NSZ'(1);
        end
        TR_POST: begin
          ram_we = 1'b1;
          wptr_d = wptr_q + NSZ'(1);
          cnt_d  = cnt_q - NSZ'(1);
          if (cnt_q == NSZ'(1)) state_d = TR_DONE;
        end
        default: ;
      endcase
      if (trig_now) begin
        trigptr_d = wptr_q;
        cnt_d     = post_len;
        state_d   = (post_len == '0) ? TR_DONE : TR_POST;
      end
    end
  end

  // one request in flight: new strobes are dropped until the ack cycle has passed
  always_comb begin
    pend_d     = debugreq & ~pend_q & ~ack_q;
    ack_d      = pend_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    trigval_d  = trigval_q;
    trigmask_d = trigmask_q;
    pretrig_d  = pretrig_q;
    regrd_d    = regrd_q;
    if (pend_d) begin
      addr_d  = debugaddr;
      wdata_d = debugwdata;
      wr_d    = debugwr;
    end
    if (reg_wr) begin
      case (addr_q[4:2])
        REG_TRIGVAL:  trigval_d  = wdata_q[8:0];
        REG_TRIGMASK: trigmask_d = wdata_q[8:0];
        REG_PRETRIG:  pretrig_d  = wdata_q[15:0];
        default: ;
      endcase
    end
    if (pend_q) begin
      case (addr_q[4:2])
        REG_STATUS:   regrd_d = status_w;
        REG_TRIGVAL:  regrd_d = {23'd0, trigval_q};
        REG_TRIGMASK: regrd_d = {23'd0, trigmask_q};
        REG_PRETRIG:  regrd_d = {16'd0, pretrig_q};
        default:      regrd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= TR_IDLE;
      wptr_q     <= '0;
      trigptr_q  <= '0;
      cnt_q      <= '0;
      pt_q       <= '0;
      trigval_q  <= '0;
      trigmask_q <= '0;
      pretrig_q  <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      regrd_q    <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      trigptr_q  <= trigptr_d;
      cnt_q      <= cnt_d;
      pt_q       <= pt_d;
      trigval_q  <= trigval_d;
      trigmask_q <= trigmask_d;
      pretrig_q  <= pretrig_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regrd_q    <= regrd_d;
    end
  end

  // trace entries are addressed relative to the oldest pre-trigger sample
  assign ram_raddr  = trigptr_q - pt_q + addr_q[LG+2 +: NSZ];
  assign lane_sel   = (LG == 0) ? '0 : addr_q[2 +: LGW];
  assign trace_word = {14'd0, ram_rdata[18*lane_sel +: 18]};

  dptrace_ram #(.W(W), .AW(NSZ)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign debugack   = ack_q;
  assign debugrdata = !ack_q ? 32'd0 : (addr_q[15] ? regrd_q : trace_word);
  assign trigd      = (state_q == TR_DONE);
  assign unused_bus = ^{addr_q, wdata_q};

endmodule

// File: tb/tb_dptrace.sv
// Randomised bench for dptrace: a capture-log model predicts state, trigger pointer and trace contents.
module tb_dptrace;
  import dptrace_pkg::*;

  localparam int NLANE = 2;
  localparam int NSZ   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] txdat = '0;
  logic [3:0]  txisk = '0;
  logic [15:0] debugaddr = '0;
  logic [31:0] debugwdata = '0;
  logic        debugwr = 1'b0;
  logic        debugreq = 1'b0;
  logic        debugack;
  logic [31:0] debugrdata;
  logic        trigd;

  dptrace #(.NLANE(NLANE), .NSZ(NSZ)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .txdat      (txdat),
    .txisk      (txisk),
    .debugaddr  (debugaddr),
    .debugwdata (debugwdata),
    .debugwr    (debugwr),
    .debugreq   (debugreq),
    .debugack   (debugack),
    .debugrdata (debugrdata),
    .trigd      (trigd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model: chronological log of every sample written since the last arm
  logic [8:0]  m_val, m_mask;
  int          m_pre, m_pt, m_k, m_trig, m_trigptr;
  bit          m_active, m_done;
  logic [35:0] m_log[$];
  bit          s_arm, s_force, s_abort;
  bit          rand_mode;
  int          inj_k = -1;
  logic [31:0] snap;

  function automatic bit model_hit();
    for (int l = 0; l < NLANE; l++)
      for (int s = 0; s < 2; s++) begin
        logic [7:0] sym;
        bit ok;
        sym = txdat[16*l+8*s +: 8];
        ok  = 1;
        for (int b = 0; b < 8; b++) if (m_mask[b] && sym[b] != m_val[b]) ok = 0;
        if (m_mask[8] && txisk[2*l+s] != m_val[8]) ok = 0;
        if (ok) return 1;
      end
    return 0;
  endfunction

  function automatic int exp_state();
    if (!m_active) return 0;
    if (m_done) return 4;
    if (m_trig >= 0) return 3;
    if (m_k < m_pt) return 1;
    return 2;
  endfunction

  task automatic model_edge();
    if (!resetn) begin
      m_active = 0; m_done = 0; m_k = 0; m_trig = -1; m_trigptr = 0;
      m_val = '0; m_mask = '0; m_pre = 0; m_pt = 0;
      m_log.delete();
    end else if (s_abort) begin
      m_active = 0; m_done = 0;
    end else if (s_arm) begin
      m_active = 1; m_done = 0; m_k = 0; m_trig = -1;
      m_pt = (m_pre > DEPTH - 1) ? DEPTH - 1 : m_pre;
      m_log.delete();
    end else if (m_active && !m_done) begin
      m_log.push_back({txisk[3:2], txdat[31:16], txisk[1:0], txdat[15:0]});
      if (m_trig < 0 && (s_force || (m_k >= m_pt && model_hit()))) begin
        m_trig = m_k;
        m_trigptr = m_k % DEPTH;
      end
      m_k++;
      if (m_trig >= 0 && m_k == m_trig + DEPTH - m_pt) m_done = 1;
    end
  endtask

  task automatic drive_tx();
    if (rand_mode) begin
      txdat = $urandom;
      txisk = 4'($urandom);
    end else begin
      txdat = {8'(m_k + 8'h40), 8'(m_k + 8'h80), 8'(m_k + 8'h20), 8'(m_k)};
      txisk = '0;
      if (m_k == inj_k) begin
        txdat[31:24] = 8'hBC;
        txisk[3] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    s_arm = 0; s_force = 0; s_abort = 0;
    #1;
    chk("trigd", {31'd0, trigd}, {31'd0, m_done});
    drive_tx();
  endtask

  task automatic bus_op(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    debugaddr = a; debugwdata = wd; debugwr = wr; debugreq = 1'b1;
    tick();
    snap = (32'(m_trigptr) << 16) | 32'(exp_state());
    debugreq = 1'b0; debugwr = 1'b0;
    if (wr && a[15] && a[4:2] == 3'd0) begin
      s_arm = wd[0]; s_force = wd[1]; s_abort = wd[2];
    end
    tick();
    if (wr && a[15]) begin
      case (a[4:2])
        3'd2: m_val = wd[8:0];
        3'd3: m_mask = wd[8:0];
        3'd4: m_pre = int'(wd[15:0]);
        default: ;
      endcase
    end
    chk("ack_hi", {31'd0, debugack}, 32'd1);
    rd = debugrdata;
    tick();
    chk("ack_lo", {31'd0, debugack}, 32'd0);
  endtask

  task automatic wreg(input int idx, input logic [31:0] d);
    logic [31:0] rd;
    bus_op(1'b1, 16'h8000 | 16'(idx << 2), d, rd);
  endtask

  task automatic rreg(input int idx, output logic [31:0] rd);
    bus_op(1'b0, 16'h8000 | 16'(idx << 2), 32'd0, rd);
  endtask

  task automatic rtrace(input int e, input int lane, output logic [31:0] rd);
    bus_op(1'b0, 16'((e << 3) | (lane << 2)), 32'd0, rd);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] rd;
    rreg(1, rd);
    chk(tag, rd, snap);
  endtask

  task automatic check_trace();
    logic [31:0] rd;
    logic [35:0] ent;
    if (m_trig < 0) return;
    for (int e = 0; e < DEPTH; e++)
      for (int lane = 0; lane < NLANE; lane++) begin
        int idx;
        idx = m_trig - m_pt + e;
        if (idx >= 0 && idx < m_k && idx >= m_k - DEPTH) begin
          rtrace(e, lane, rd);
          ent = m_log[idx];
          chk("trace", rd, {14'd0, ent[18*lane +: 18]});
        end
      end
  endtask

  task automatic wait_write(input int kk);
    int g = 0;
    while (m_k <= kk && g < 200) begin tick(); g++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (trigd !== 1'b1 && n < 60) begin tick(); n++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;

    resetn = 1'b0;
    tick(); tick();
    chk("rst_ack", {31'd0, debugack}, 32'd0);
    chk("rst_rdata", debugrdata, 32'd0);
    chk("rst_trigd", {31'd0, trigd}, 32'd0);
    resetn = 1'b1;
    tick();
    rreg(1, rd); chk("rst_status", rd, 32'd0);
    rreg(2, rd); chk("rst_trigval", rd, 32'd0);
    rreg(3, rd); chk("rst_trigmask", rd, 32'd0);
    rreg(4, rd); chk("rst_pretrig", rd, 32'd0);

    // K28.5 on lane 1 slot 1 at sample 20, 4 pre-trigger entries
    wreg(4, 32'd4);
    wreg(2, 32'(SYM_BE));
    wreg(3, 32'h1FF);
    rreg(2, rd); chk("trigval_rb", rd, 32'h1BC);
    inj_k = 20;
    wreg(0, 32'h1);
    wait_write(20);
    wait_done(n);
    chk("t1_done_lat", n, 11);
    check_status("t1_status");
    chk("t1_trigptr", {28'd0, snap[19:16]}, 32'd4);
    rtrace(4, 1, rd);
    chk("t1_trig_isk", {30'd0, rd[17:16]}, 32'd2);
    chk("t1_trig_sym", {24'd0, rd[15:8]}, 32'hBC);
    for (int e = 0; e < 4; e++) begin
      rtrace(e, 0, rd);
      chk("t1_pre_sample", {24'd0, rd[7:0]}, 32'(16 + e));
    end
    check_trace();
    inj_k = -1;

    bus_op(1'b1, 16'h8018, 32'hFFFF_FFFF, rd);
    bus_op(1'b0, 16'h8018, 32'd0, rd); chk("unmapped", rd, 32'd0);
    rreg(0, rd); chk("ctrl_rd", rd, 32'd0);

    // mask 0 triggers on the first ARMED cycle; no pre-trigger phase
    wreg(3, 32'd0);
    wreg(4, 32'd0);
    wreg(0, 32'h1);
    wait_done(n);
    chk("pt0_done_lat", n, 15);
    check_status("pt0_status");
    chk("pt0_trigptr", {28'd0, snap[19:16]}, 32'd0);
    check_trace();

    // oversized pretrigger clamps to DEPTH-1
    wreg(3, 32'h1FF);
    wreg(4, 32'd100);
    inj_k = 20;
    wreg(0, 32'h1);
    wait_write(20);
    chk("clamp_done", {31'd0, trigd}, 32'd1);
    rtrace(15, 1, rd);
    chk("clamp_trig_sym", {24'd0, rd[15:8]}, 32'hBC);
    check_status("clamp_status");
    chk("clamp_trigptr", {28'd0, snap[19:16]}, 32'd4);
    check_trace();
    inj_k = -1;

    // force during PRE after 2 writes
    wreg(4, 32'd6);
    wreg(0, 32'h1);
    wreg(0, 32'h2);
    wait_done(n);
    chk("force_done_lat", n, 8);
    check_status("force_status");
    chk("force_trigptr", {28'd0, snap[19:16]}, 32'd2);
    check_trace();

    // abort during POST
    wreg(4, 32'd2);
    inj_k = 5;
    wreg(0, 32'h1);
    wait_write(5);
    tick(); tick();
    wreg(0, 32'h4);
    for (int i = 0; i < 5; i++) tick();
    rreg(1, rd); chk("abort_state", {29'd0, rd[2:0]}, 32'd0);
    inj_k = -1;

    // arm and abort together: abort wins
    wreg(0, 32'h5);
    rreg(1, rd); chk("armabort_state", {29'd0, rd[2:0]}, 32'd0);

    // back-to-back requests produce a single ack
    debugaddr = 16'h8008; debugwr = 1'b0; debugreq = 1'b1;
    tick(); tick();
    debugreq = 1'b0;
    n = debugack ? 1 : 0;
    for (int i = 0; i < 4; i++) begin tick(); if (debugack) n++; end
    chk("b2b_acks", n, 1);

    // randomised captures
    rand_mode = 1;
    for (int it = 0; it < 6; it++) begin
      wreg(2, $urandom & 32'h1FF);
      wreg(3, $urandom & 32'h1FF);
      wreg(4, $urandom_range(0, 20));
      wreg(0, 32'h1);
      if (it % 2 == 1) wreg(0, 32'h2);
      wait_done(n);
      check_status("rnd_status");
      if (m_done) check_trace();
      else wreg(0, 32'h4);
    end
    rand_mode = 0;

    // reset during ARMED, then rearm with reset register values
    wreg(2, 32'h1BC);
    wreg(3, 32'h1FF);
    wreg(4, 32'd0);
    wreg(0, 32'h1);
    tick(); tick(); tick();
    debugaddr = 16'h8004; debugreq = 1'b1;
    resetn = 1'b0;
    tick();
    chk("midrst_ack", {31'd0, debugack}, 32'd0);
    chk("midrst_rdata", debugrdata, 32'd0);
    chk("midrst_trigd", {31'd0, trigd}, 32'd0);
    debugreq = 1'b0;
    resetn = 1'b1;
    tick();
    rreg(1, rd); chk("midrst_status", rd, 32'd0);
    rreg(3, rd); chk("midrst_mask", rd, 32'd0);
    wreg(0, 32'h1);
    wait_done(n);
    chk("rearm_done_lat", n, 15);
    check_status("rearm_status");
    check_trace();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
